// File: rtl/audio_clkgen.sv
// -----------------------------------------------------------------------------
// audio_clkgen
//
// Derives codec-facing audio timing from the 256fs system clock and sequences
// codec power-up. After reset, or after enable has been low, the block holds
// the codec in reset for CODEC_RST_CYCLES cycles. It then runs the clocks for
// SETTLE_FRAMES full frames before it declares the audio path ready.
//
// Ports:
//   clk_256fs      in   system clock, 256x sample rate
//   rst_n          in   asynchronous active-low reset
//   enable         in   soft enable; low restarts the power-up sequence
//   codec_rst_n    out  active-low codec reset
//   bclk           out  bit clock, 64fs, 50% duty
//   lrck           out  word clock, fs, low = left half-frame
//                       (TDM frame-sync when AUDIO_CLKGEN_TDM_EN is defined)
//   sample_strobe  out  one-cycle pulse per frame while running
//   ready          out  high once the audio path is running
//   frame_cnt[15:0] out frames elapsed while running, wraps
//   slot[1:0]      out  TDM slot index (only with AUDIO_CLKGEN_TDM_EN)
//
// Optional build macro: AUDIO_CLKGEN_TDM_EN
//   When defined, lrck is a one-bclk frame-sync pulse at the start of each
//   frame and the slot port is added. When undefined, lrck is a 50% fs clock.
// -----------------------------------------------------------------------------
module audio_clkgen #(
  parameter int unsigned CODEC_RST_CYCLES = 1024,
  parameter int unsigned SETTLE_FRAMES    = 16
) (
  input  logic        clk_256fs,
  input  logic        rst_n,
  input  logic        enable,
  output logic        codec_rst_n,
  output logic        bclk,
  output logic        lrck,
  output logic        sample_strobe,
  output logic        ready,
  output logic [15:0] frame_cnt
`ifdef AUDIO_CLKGEN_TDM_EN
  ,
  output logic [1:0]  slot
`endif
);

  localparam logic [15:0] HOLD_LAST   = 16'(CODEC_RST_CYCLES - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  phase, phase_nx;
  logic [15:0] hold_cnt, hold_cnt_nx;
  logic [7:0]  settle_cnt, settle_cnt_nx;
  logic [15:0] frame_cnt_nx;
  logic        frame_end;
  logic        running_nx;
  logic        codec_rst_n_nx, bclk_nx, lrck_nx, strobe_nx, ready_nx;
`ifdef AUDIO_CLKGEN_TDM_EN
  logic [1:0]  slot_nx;
`endif

  assign frame_end = (phase == 8'hFF);

  // Next-state logic. Every output is computed from the next state and next
  // phase so the registered outputs line up with the phase counter edge.
  always_comb begin
    state_nx      = state;
    phase_nx      = 8'd0;
    hold_cnt_nx   = 16'd0;
    settle_cnt_nx = settle_cnt;
    frame_cnt_nx  = 16'd0;

    unique case (state)
      ST_HOLD: begin
        settle_cnt_nx = 8'd0;
        if (enable) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nx = ST_SETTLE;
          end else begin
            hold_cnt_nx = hold_cnt + 16'd1;
          end
        end
      end

      ST_SETTLE: begin
        if (!enable) begin
          state_nx      = ST_HOLD;
          settle_cnt_nx = 8'd0;
        end else begin
          phase_nx = phase + 8'd1;
          if (frame_end) begin
            if (settle_cnt == SETTLE_LAST) begin
              state_nx      = ST_RUN;
              settle_cnt_nx = 8'd0;
            end else begin
              settle_cnt_nx = settle_cnt + 8'd1;
            end
          end
        end
      end

      ST_RUN: begin
        if (!enable) begin
          // Abandon the frame; the count clears and no increment happens even
          // if this is the last cycle of a frame.
          state_nx = ST_HOLD;
        end else begin
          phase_nx     = phase + 8'd1;
          frame_cnt_nx = frame_cnt + 16'(frame_end);
        end
      end

      default: begin
        state_nx      = ST_HOLD;
        settle_cnt_nx = 8'd0;
      end
    endcase

    running_nx     = (state_nx != ST_HOLD);
    codec_rst_n_nx = running_nx;
    bclk_nx        = running_nx && phase_nx[1];
`ifdef AUDIO_CLKGEN_TDM_EN
    lrck_nx        = running_nx && (phase_nx < 8'd4);
    slot_nx        = running_nx ? phase_nx[7:6] : 2'b00;
`else
    lrck_nx        = running_nx && phase_nx[7];
`endif
    ready_nx       = (state_nx == ST_RUN);
    strobe_nx      = ready_nx && (phase_nx == 8'hFF);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_HOLD;
      phase         <= 8'd0;
      hold_cnt      <= 16'd0;
      settle_cnt    <= 8'd0;
      codec_rst_n   <= 1'b0;
      bclk          <= 1'b0;
      lrck          <= 1'b0;
      sample_strobe <= 1'b0;
      ready         <= 1'b0;
      frame_cnt     <= 16'd0;
`ifdef AUDIO_CLKGEN_TDM_EN
      slot          <= 2'b00;
`endif
    end else begin
      state         <= state_nx;
      phase         <= phase_nx;
      hold_cnt      <= hold_cnt_nx;
      settle_cnt    <= settle_cnt_nx;
      codec_rst_n   <= codec_rst_n_nx;
      bclk          <= bclk_nx;
      lrck          <= lrck_nx;
      sample_strobe <= strobe_nx;
      ready         <= ready_nx;
      frame_cnt     <= frame_cnt_nx;
`ifdef AUDIO_CLKGEN_TDM_EN
      slot          <= slot_nx;
`endif
    end
  end

endmodule

// File: tb/tb_audio_clkgen.sv
// -----------------------------------------------------------------------------
// tb_audio_clkgen
//
// Scoreboard bench for audio_clkgen. A reference model tracks how many
// consecutive enabled clock edges have elapsed since the last restart and
// derives every expected output from that count with plain arithmetic. The
// expectation for each cycle is queued at the clock edge, and a monitor pops
// and compares on the opposite edge.
// -----------------------------------------------------------------------------
module tb_audio_clkgen;

  localparam int C = 4;   // CODEC_RST_CYCLES
  localparam int S = 2;   // SETTLE_FRAMES

  logic        clk_256fs = 1'b0;
  logic        rst_n     = 1'b0;
  logic        enable    = 1'b0;
  logic        codec_rst_n, bclk, lrck, sample_strobe, ready;
  logic [15:0] frame_cnt;
`ifdef AUDIO_CLKGEN_TDM_EN
  logic [1:0]  slot;
`endif

  audio_clkgen #(
    .CODEC_RST_CYCLES(C),
    .SETTLE_FRAMES   (S)
  ) dut (
    .clk_256fs    (clk_256fs),
    .rst_n        (rst_n),
    .enable       (enable),
    .codec_rst_n  (codec_rst_n),
    .bclk         (bclk),
    .lrck         (lrck),
    .sample_strobe(sample_strobe),
    .ready        (ready),
    .frame_cnt    (frame_cnt)
`ifdef AUDIO_CLKGEN_TDM_EN
    ,
    .slot         (slot)
`endif
  );

  always #5 clk_256fs = ~clk_256fs;

  typedef struct packed {
    logic        codec_rst_n;
    logic        bclk;
    logic        lrck;
    logic        strobe;
    logic        ready;
    logic [15:0] frame_cnt;
    logic [1:0]  slot;
  } exp_t;

  exp_t exp_q[$];
  int   n_en   = 0;   // consecutive enabled edges since last restart
  int   vec    = 0;
  int   fails  = 0;

  // Expected outputs after n consecutive enabled edges.
  function automatic exp_t model_out(input int n);
    exp_t e;
    int   k, ph;
    e = '0;
    if (n >= C) begin
      k  = n - C;            // edges since the codec came out of reset
      ph = k % 256;          // position within the current frame
      e.codec_rst_n = 1'b1;
      e.bclk        = ((ph / 2) % 2) == 1;
`ifdef AUDIO_CLKGEN_TDM_EN
      e.lrck        = (ph < 4);
`else
      e.lrck        = (ph >= 128);
`endif
      e.slot        = 2'(ph / 64);
      e.ready       = (k >= 256 * S);
      e.strobe      = e.ready && (ph == 255);
      e.frame_cnt   = e.ready ? 16'((k - 256 * S) / 256) : 16'd0;
    end
    return e;
  endfunction

  function automatic bit in_run();
    return (n_en >= C) && ((n_en - C) >= 256 * S);
  endfunction

  function automatic int cur_phase();
    return (n_en >= C) ? ((n_en - C) % 256) : -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: advance on each clock edge, restart on reset.
  always @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      n_en = 0;
    end else begin
      if (enable) n_en = n_en + 1;
      else        n_en = 0;
      exp_q.push_back(model_out(n_en));
    end
  end

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge clk_256fs) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("codec_rst_n",   32'(codec_rst_n),   32'(e.codec_rst_n));
      chk("bclk",          32'(bclk),          32'(e.bclk));
      chk("lrck",          32'(lrck),          32'(e.lrck));
      chk("sample_strobe", 32'(sample_strobe), 32'(e.strobe));
      chk("ready",         32'(ready),         32'(e.ready));
      chk("frame_cnt",     32'(frame_cnt),     32'(e.frame_cnt));
`ifdef AUDIO_CLKGEN_TDM_EN
      chk("slot",          32'(slot),          32'(e.slot));
`endif
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_codec_rst_n"}, 32'(codec_rst_n),   32'd0);
    chk({tag, "_bclk"},        32'(bclk),          32'd0);
    chk({tag, "_lrck"},        32'(lrck),          32'd0);
    chk({tag, "_strobe"},      32'(sample_strobe), 32'd0);
    chk({tag, "_ready"},       32'(ready),         32'd0);
    chk({tag, "_frame_cnt"},   32'(frame_cnt),     32'd0);
  endtask

  // Wait (bounded) until the model says the DUT is running at a given phase.
  task automatic wait_run_phase(input int ph, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_256fs);
      if (in_run() && cur_phase() == ph) return;
    end
    vec++;
    fails++;
    $display("FAIL wait_run_phase: no RUN phase %0d within %0d cycles", ph, budget);
  endtask

  initial begin
    int strobes, lrck_hi, bclk_rise;
    logic bclk_prev;

    // Reset state, with enable already high through the release.
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk_256fs);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Reach RUN, then measure a 1024-cycle window.
    repeat (C + 256 * S + 8) @(negedge clk_256fs);
    strobes = 0; lrck_hi = 0; bclk_rise = 0;
    bclk_prev = bclk;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk_256fs);
      if (sample_strobe) strobes++;
      if (lrck) lrck_hi++;
      if (bclk && !bclk_prev) bclk_rise++;
      bclk_prev = bclk;
    end
    chk("win_strobes",   32'(strobes),   32'd4);
`ifdef AUDIO_CLKGEN_TDM_EN
    chk("win_lrck_high", 32'(lrck_hi),   32'd16);
`else
    chk("win_lrck_high", 32'(lrck_hi),   32'd512);
`endif
    chk("win_bclk_rise", 32'(bclk_rise), 32'd256);

    // Drop enable mid-frame in RUN, then restart.
    wait_run_phase(100, 300);
    enable = 1'b0;
    repeat (3) @(negedge clk_256fs);
    enable = 1'b1;

    // Asynchronous reset pulse, off-edge, mid-RUN.
    wait_run_phase(37, 1200);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    rst_n = 1'b1;

    // Interrupt the hold count at 2, then let it restart.
    repeat (2) @(negedge clk_256fs);
    enable = 1'b0;
    repeat (3) @(negedge clk_256fs);
    enable = 1'b1;

    // Enable falls in the strobe cycle: strobe stays, no count increment.
    wait_run_phase(255, 1200);
    enable = 1'b0;
    repeat (2) @(negedge clk_256fs);
    enable = 1'b1;

    // Randomized enable pattern.
    for (int r = 0; r < 12; r++) begin
      enable = 1'b1;
      repeat ($urandom_range(1, 1100)) @(negedge clk_256fs);
      enable = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk_256fs);
    end
    enable = 1'b1;
    repeat (C + 256 * S + 300) @(negedge clk_256fs);

    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

endmodule
